// File: rtl/wb_gpio_pkg.sv
// Shared register map, field widths and synchroniser warm-up length for wb_gpio_ctrl.
package wb_gpio_pkg;

  localparam int unsigned WB_ADR_W  = 5;
  localparam int unsigned WB_DAT_W  = 32;
  localparam int unsigned WB_SEL_W  = WB_DAT_W / 8;
  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned WARM_W    = 3;

  typedef enum logic [REG_IDX_W-1:0] {
    REG_DATA_IN    = 3'd0,
    REG_DATA_OUT   = 3'd1,
    REG_DIR        = 3'd2,
    REG_IRQ_EN     = 3'd3,
    REG_IRQ_EDGE   = 3'd4,
    REG_IRQ_STATUS = 3'd5,
    REG_RSVD6      = 3'd6,
    REG_RSVD7      = 3'd7
  } reg_idx_e;

  // Cycles after reset before edge detection is trusted: the delay flop must
  // have loaded from a fully refilled sync chain first.
  function automatic logic [WARM_W-1:0] warmup_count(input int unsigned sync_stages);
    return WARM_W'(sync_stages + 1);
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser plus one delay stage; emits per-line rise/fall pulses.
// Level appears SYNC_STAGES-1 edges after capture; pulses are suppressed during post-reset warm-up.
module gpio_sync_edge
  import wb_gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pad,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam logic [WARM_W-1:0] WARM_DONE = warmup_count(SYNC_STAGES);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  dly_q;
  logic [WARM_W-1:0]                 warm_q;
  logic                              detect_en;

  assign level     = sync_q[SYNC_STAGES-1];
  assign detect_en = (warm_q == WARM_DONE);
  assign rise      = detect_en ? (level & ~dly_q) : '0;
  assign fall      = detect_en ? (~level & dly_q) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= '0;
      warm_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
      dly_q  <= level;
      if (!detect_en) begin
        warm_q <= warm_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_gpio_ctrl.sv
// Wishbone classic GPIO controller: direction/output registers, synchronised inputs, edge IRQs.
// Every access acks one cycle after cyc&stb; a new access needs ack to drop first.
module wb_gpio_ctrl
  import wb_gpio_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] RST_DIR     = '0
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic [WB_ADR_W-1:0]   wb_adr_i,
  input  logic [WB_DAT_W-1:0]   wb_dat_i,
  input  logic [WB_SEL_W-1:0]   wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [WB_DAT_W-1:0]   wb_dat_o,
  output logic                  wb_ack_o,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe_o,
  output logic                  irq_o
);

  logic [GPIO_WIDTH-1:0] data_out_q, dir_q, irq_en_q, irq_edge_q, irq_status_q;
  logic [GPIO_WIDTH-1:0] data_in, rise, fall, set_evt, clr_mask, wr_mask, wr_dat;
  logic [WB_DAT_W-1:0]   sel_mask, rdata;
  logic                  req, wr_en;
  reg_idx_e              reg_idx;
  logic                  unused_bits;

  gpio_sync_edge #(
    .WIDTH       (GPIO_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .pad   (gpio_i),
    .level (data_in),
    .rise  (rise),
    .fall  (fall)
  );

  assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_en    = req & wb_we_i;
  assign reg_idx  = reg_idx_e'(wb_adr_i[4:2]);
  assign sel_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wr_mask  = sel_mask[GPIO_WIDTH-1:0];
  assign wr_dat   = wb_dat_i[GPIO_WIDTH-1:0];

  // Byte address bits and data/lane bits beyond GPIO_WIDTH carry no meaning here.
  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i, sel_mask};

  assign set_evt  = irq_en_q & ((irq_edge_q & rise) | (~irq_edge_q & fall));
  assign clr_mask = (wr_en && reg_idx == REG_IRQ_STATUS) ? (wr_dat & wr_mask) : '0;

  assign gpio_o    = data_out_q;
  assign gpio_oe_o = dir_q;

  always_comb begin
    rdata = '0;
    case (reg_idx)
      REG_DATA_IN:    rdata[GPIO_WIDTH-1:0] = data_in;
      REG_DATA_OUT:   rdata[GPIO_WIDTH-1:0] = data_out_q;
      REG_DIR:        rdata[GPIO_WIDTH-1:0] = dir_q;
      REG_IRQ_EN:     rdata[GPIO_WIDTH-1:0] = irq_en_q;
      REG_IRQ_EDGE:   rdata[GPIO_WIDTH-1:0] = irq_edge_q;
      REG_IRQ_STATUS: rdata[GPIO_WIDTH-1:0] = irq_status_q;
      default:        rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wb_ack_o     <= 1'b0;
      wb_dat_o     <= '0;
      data_out_q   <= '0;
      dir_q        <= RST_DIR[GPIO_WIDTH-1:0];
      irq_en_q     <= '0;
      irq_edge_q   <= '0;
      irq_status_q <= '0;
      irq_o        <= 1'b0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= req ? rdata : '0;
      if (wr_en) begin
        case (reg_idx)
          REG_DATA_OUT: data_out_q <= (data_out_q & ~wr_mask) | (wr_dat & wr_mask);
          REG_DIR:      dir_q      <= (dir_q      & ~wr_mask) | (wr_dat & wr_mask);
          REG_IRQ_EN:   irq_en_q   <= (irq_en_q   & ~wr_mask) | (wr_dat & wr_mask);
          REG_IRQ_EDGE: irq_edge_q <= (irq_edge_q & ~wr_mask) | (wr_dat & wr_mask);
          default:      ;
        endcase
      end
      // A fresh edge outranks a write-1-to-clear landing on the same cycle.
      irq_status_q <= (irq_status_q & ~clr_mask) | set_evt;
      irq_o        <= |(irq_status_q & irq_en_q);
    end
  end

endmodule

// File: tb/tb_wb_gpio_ctrl.sv
// Directed bench for wb_gpio_ctrl: register access, output path, input latency, IRQ rules, reset abort.
module tb_wb_gpio_ctrl;

  localparam int unsigned W          = 8;
  localparam logic [31:0] TB_RST_DIR = 32'h0000_0081;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  adr   = '0;
  logic [31:0] dat_w = '0;
  logic [3:0]  sel   = '0;
  logic        we    = 1'b0;
  logic        cyc   = 1'b0;
  logic        stb   = 1'b0;
  logic [31:0] dat_r;
  logic        ack;
  logic [W-1:0] gpio_in = '0;
  logic [W-1:0] gpio_out;
  logic [W-1:0] gpio_oe;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_gpio_ctrl #(
    .GPIO_WIDTH  (W),
    .SYNC_STAGES (2),
    .RST_DIR     (TB_RST_DIR)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb_adr_i   (adr),
    .wb_dat_i   (dat_w),
    .wb_sel_i   (sel),
    .wb_we_i    (we),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_dat_o   (dat_r),
    .wb_ack_o   (ack),
    .gpio_i     (gpio_in),
    .gpio_o     (gpio_out),
    .gpio_oe_o  (gpio_oe),
    .irq_o      (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One access; checks ack arrives and lasts exactly one cycle while cyc&stb stay high.
  task automatic wb_access(input logic w, input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd);
    logic got;
    got = 1'b0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
    rd = dat_r;
    chk("ack_seen", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    chk("ack_one_cycle", {31'd0, ack}, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd_ignored;
    wb_access(1'b1, a, d, s, rd_ignored);
  endtask

  task automatic wb_rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    wb_access(1'b0, a, 32'd0, 4'hF, rd);
    chk(tag, rd, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion, expected finish before 100000ns");
    $fatal(1);
  end

  initial begin
    logic [31:0] rst_exp [8];
    rst_exp = '{32'h0, 32'h0, TB_RST_DIR, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    // Reset state
    #1 rst_n = 1'b0;
    #3;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dat_o", dat_r, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_gpio_o", {24'd0, gpio_out}, 32'd0);
    chk("rst_gpio_oe", {24'd0, gpio_oe}, TB_RST_DIR);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wb_rd_chk($sformatf("rst_rd_off%0d", i), 5'(i * 4), rst_exp[i]);
    end

    // Output path and byte lanes
    wb_wr(5'h08, 32'h0000_00FF, 4'b0001);
    chk("dir_ff_oe", {24'd0, gpio_oe}, 32'h0000_00FF);
    wb_wr(5'h04, 32'h0000_00A5, 4'b0001);
    chk("dout_a5", {24'd0, gpio_out}, 32'h0000_00A5);
    wb_wr(5'h04, 32'hFFFF_FFFF, 4'b0010);
    chk("sel1_dout_kept", {24'd0, gpio_out}, 32'h0000_00A5);
    wb_wr(5'h08, 32'h0000_0000, 4'b0010);
    chk("sel1_dir_kept", {24'd0, gpio_oe}, 32'h0000_00FF);
    wb_rd_chk("adr_low_ignored", 5'h07, 32'h0000_00A5);
    wb_wr(5'h08, 32'hFFFF_FF7E, 4'hF);
    wb_rd_chk("dir_upper_zero", 5'h08, 32'h0000_007E);
    chk("dir_7e_oe", {24'd0, gpio_oe}, 32'h0000_007E);
    wb_wr(5'h04, 32'hFFFF_FF96, 4'hF);
    wb_rd_chk("dout_96", 5'h04, 32'h0000_0096);
    wb_wr(5'h18, 32'hFFFF_FFFF, 4'hF);
    wb_rd_chk("rsvd6_zero", 5'h18, 32'h0);
    wb_rd_chk("rsvd7_zero", 5'h1C, 32'h0);
    chk("rsvd_wr_no_side", {24'd0, gpio_out}, 32'h0000_0096);
    wb_wr(5'h00, 32'h0000_00FF, 4'hF);
    wb_rd_chk("din_ro", 5'h00, 32'h0);

    // Input latency and rising-edge IRQ on line 3
    wb_wr(5'h0C, 32'h0000_0008, 4'b0001);
    wb_wr(5'h10, 32'h0000_0008, 4'b0001);
    @(negedge clk);
    gpio_in[3] = 1'b1;
    @(posedge clk); #1;
    chk("lat_irq_E", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("lat_irq_E1", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("lat_irq_E2", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("lat_irq_E3", {31'd0, irq}, 32'd1);
    wb_rd_chk("din_bit3", 5'h00, 32'h0000_0008);
    wb_rd_chk("status_bit3", 5'h14, 32'h0000_0008);
    wb_wr(5'h14, 32'h0000_0008, 4'b0001);
    chk("w1c3_irq", {31'd0, irq}, 32'd0);
    wb_rd_chk("status_cleared3", 5'h14, 32'h0);

    // Polarity and masking on line 0
    wb_wr(5'h0C, 32'h0000_0001, 4'b0001);
    wb_wr(5'h10, 32'h0000_0000, 4'b0001);
    @(negedge clk);
    gpio_in[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rise_no_irq", {31'd0, irq}, 32'd0);
    wb_rd_chk("rise_no_status", 5'h14, 32'h0);
    @(negedge clk);
    gpio_in[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("fall_irq", {31'd0, irq}, 32'd1);
    wb_rd_chk("fall_status", 5'h14, 32'h0000_0001);
    wb_wr(5'h0C, 32'h0000_0000, 4'b0001);
    chk("masked_irq", {31'd0, irq}, 32'd0);
    wb_rd_chk("masked_status_kept", 5'h14, 32'h0000_0001);

    // Set beats W1C on the same edge
    wb_wr(5'h14, 32'h0000_0001, 4'b0001);
    wb_rd_chk("pre_coll_clear", 5'h14, 32'h0);
    wb_wr(5'h0C, 32'h0000_0001, 4'b0001);
    @(negedge clk);
    gpio_in[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("coll_prep_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    gpio_in[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    wb_wr(5'h14, 32'h0000_0001, 4'b0001);
    wb_rd_chk("coll_set_wins", 5'h14, 32'h0000_0001);
    chk("coll_irq", {31'd0, irq}, 32'd1);
    wb_wr(5'h14, 32'h0000_0001, 4'b0001);
    chk("post_w1c_irq", {31'd0, irq}, 32'd0);
    wb_rd_chk("post_w1c_status", 5'h14, 32'h0);

    // Reset in the middle of a write
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 5'h04; dat_w = 32'h0000_003C; sel = 4'hF;
    #2;
    rst_n = 1'b0;
    gpio_in = 8'hFF;
    #1;
    chk("abort_async_gpio_o", {24'd0, gpio_out}, 32'h0);
    chk("abort_async_oe", {24'd0, gpio_oe}, TB_RST_DIR);
    @(posedge clk); #1;
    chk("abort_no_ack", {31'd0, ack}, 32'd0);
    chk("abort_no_write", {24'd0, gpio_out}, 32'h0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("warmup_irq%0d", i), {31'd0, irq}, 32'd0);
    end
    wb_rd_chk("warmup_status", 5'h14, 32'h0);
    wb_rd_chk("abort_dout", 5'h04, 32'h0);
    wb_rd_chk("din_ff", 5'h00, 32'h0000_00FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
